imem_loader: RTL
================

# imem_loader

Sequencing controller that fills the instruction memory before the core runs. It accepts a stream of 32-bit instruction words over a valid/ready handshake and packs them in pairs. It drives the memory's external-load port (load enable, address, two data words) one write per pair, then releases the core. It sits between the test/boot interface and the instruction memory and owns that memory's load-enable for its whole lifetime.

## Interface
- INS_ADDRESS, 9, width of the instruction-memory write address (depth 2^INS_ADDRESS pair-slots)
- INS_W, 32, instruction word width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to begin a load
- base_addr  in  INS_ADDRESS  first memory address, sampled with start
- word_count  in  INS_ADDRESS+1  number of instruction words to load, sampled with start
- abort  in  1  cancel any load; return to IDLE
- in_valid  in  1  in_data holds a word
- in_data  in  INS_W  instruction word
- in_ready  out  1  controller accepts in_data this cycle
- load_en  out  1  memory external-load enable (write strobe)
- load_addr  out  INS_ADDRESS  memory write address
- load_data1  out  INS_W  first (even) word of the pair
- load_data2  out  INS_W  second (odd) word of the pair, 0 when padded
- busy  out  1  load in progress
- done  out  1  load completed; level, held
- overflow  out  1  sticky: last start rejected for exceeding memory depth
- core_run  out  1  core may fetch; equals done

## Operation
- States: IDLE, FILL_LO, FILL_HI, WRITE, DONE (enum in package).
- IDLE/DONE + start (no abort): compute pairs = ceil(word_count/2).
  - If base_addr + pairs > 2^INS_ADDRESS: overflow<=1, next IDLE, no writes.
  - Else if word_count == 0: overflow<=0, next DONE.
  - Else: overflow<=0, latch addr=base_addr, remaining=word_count, next FILL_LO.
- FILL_LO: in_ready=1. On handshake: data1<=in_data, remaining-=1. Next FILL_HI if remaining (pre-decrement) > 1, else data2<=0, next WRITE.
- FILL_HI: in_ready=1. On handshake: data2<=in_data, remaining-=1, next WRITE.
- WRITE: load_en=1 for exactly one cycle, in_ready=0. Next: addr+=1. Go to FILL_LO if remaining > 0, else DONE.
- DONE: done=core_run=1, held until start or abort.
- start while in FILL_LO/FILL_HI/WRITE: ignored.
- abort: any state goes to IDLE next cycle and clears done. Writes already committed remain in memory. overflow is unchanged.
- abort and start in the same cycle: abort wins.
- Address arithmetic: addr is INS_ADDRESS bits wide. The overflow check guarantees no wrap. The check itself uses INS_ADDRESS+1-bit arithmetic.

## Timing
- All outputs are registered or decoded from registered state; none combinational from inputs except in_ready, which is a state decode.
- Reset values: in_ready=0, load_en=0, load_addr=0, load_data1=0, load_data2=0, busy=0, done=0, overflow=0, core_run=0; state IDLE.
- start at edge t puts FILL_LO active from t+1; the first in_ready is visible in cycle t+1.
- load_addr/load_data1/load_data2 are stable for the whole WRITE cycle and hold their values outside it.
- busy=1 in FILL_LO, FILL_HI, WRITE.
- Throughput: one pair per 3 cycles with in_valid held high.
- abort sampled in the WRITE cycle: the write still occurs (load_en already high), then the FSM goes to IDLE.
- Reset mid-load: immediate return to all reset values; no partial write strobe.

## Structure
- imem_loader_pkg: state enum type; localparam for pair-slot depth (2^INS_ADDRESS).
- Single FSM module, no sub-module. Pair packing is two registers, too small to separate.

## Test plan
- base_addr=0, word_count=4, words 0x11,0x22,0x33,0x44, in_valid always high -> two load_en pulses: (addr 0, 0x11, 0x22), then (addr 1, 0x33, 0x44); done=1 at the 7th cycle after start.
- word_count=3 from base 5 -> writes (5, w0, w1) and (6, w2, 0x0); done=1; core_run=1.
- base_addr=510, word_count=6 (INS_ADDRESS=9) -> overflow=1, no load_en, stays IDLE. A following valid start clears overflow.
- in_valid toggled 1,0,0,1 -> in_ready held high; capture only on handshake cycles; pair data correct.
- abort asserted during FILL_HI after one write -> exactly one load_en pulse total; IDLE next cycle; done=0.
- rst_n pulled low during WRITE, asynchronously -> load_en falls without waiting for a clock edge; all outputs return to reset values.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// +-----------------------------------------------------------------------+
// | imem_loader_pkg : shared FSM state type and memory-depth constants     |
// | Revision 1.0                                                           |
// +-----------------------------------------------------------------------+
`default_nettype none

package imem_loader_pkg;

  localparam int unsigned DEF_INS_ADDRESS = 9;
  localparam int unsigned DEF_INS_W       = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FILL_LO = 3'd1,
    FILL_HI = 3'd2,
    WRITE   = 3'd3,
    DONE    = 3'd4
  } state_e;

  function automatic int unsigned pair_slots(int unsigned aw);
    return 32'd1 << aw;
  endfunction

  localparam int unsigned PAIR_SLOTS = pair_slots(DEF_INS_ADDRESS);

endpackage

`default_nettype wire

// File: rtl/imem_loader_if.sv
// +-----------------------------------------------------------------------+
// | imem_loader_if : instruction stream handshake plus memory load port    |
// | Revision 1.0                                                           |
// +-----------------------------------------------------------------------+
`default_nettype none

interface imem_loader_if #(
  parameter int INS_ADDRESS = 9,
  parameter int INS_W       = 32
) ();

  logic                   in_valid;
  logic [INS_W-1:0]       in_data;
  logic                   in_ready;
  logic                   load_en;
  logic [INS_ADDRESS-1:0] load_addr;
  logic [INS_W-1:0]       load_data1;
  logic [INS_W-1:0]       load_data2;

  // master: word source and memory side; slave: the loader itself
  modport master (
    output in_valid, in_data,
    input  in_ready, load_en, load_addr, load_data1, load_data2
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, load_en, load_addr, load_data1, load_data2
  );

endinterface

`default_nettype wire

// File: rtl/imem_loader.sv
// +-----------------------------------------------------------------------+
// | imem_loader : packs streamed instruction words in pairs and writes     |
// |               them to instruction memory, then releases the core       |
// | Revision 1.0                                                           |
// +-----------------------------------------------------------------------+
`default_nettype none

module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int INS_ADDRESS = DEF_INS_ADDRESS,
  parameter int INS_W       = DEF_INS_W
) (
  input  wire logic                   clk,
  input  wire logic                   rst_n,
  input  wire logic                   start,
  input  wire logic [INS_ADDRESS-1:0] base_addr,
  input  wire logic [INS_ADDRESS:0]   word_count,
  input  wire logic                   abort,
  imem_loader_if.slave                bus,
  output logic                        busy,
  output logic                        done,
  output logic                        overflow,
  output logic                        core_run
);

  localparam logic [INS_ADDRESS:0]   SLOT_LIMIT = (INS_ADDRESS+1)'(pair_slots(INS_ADDRESS));
  localparam logic [INS_ADDRESS:0]   ONE_WORD   = (INS_ADDRESS+1)'(1);
  localparam logic [INS_ADDRESS-1:0] ONE_SLOT   = INS_ADDRESS'(1);

  state_e                 state_q,      state_d;
  logic [INS_ADDRESS-1:0] addr_q,       addr_d;
  logic [INS_ADDRESS:0]   remaining_q,  remaining_d;
  logic [INS_W-1:0]       lo_q,         lo_d;
  logic                   load_en_q,    load_en_d;
  logic [INS_ADDRESS-1:0] load_addr_q,  load_addr_d;
  logic [INS_W-1:0]       load_data1_q, load_data1_d;
  logic [INS_W-1:0]       load_data2_q, load_data2_d;
  logic                   busy_q,       busy_d;
  logic                   done_q,       done_d;
  logic                   overflow_q,   overflow_d;

  logic                   w_in_ready;
  logic                   w_handshake;
  logic [INS_ADDRESS:0]   w_pairs;
  logic [INS_ADDRESS:0]   w_end;

  assign w_in_ready  = (state_q == FILL_LO) || (state_q == FILL_HI);
  assign w_handshake = w_in_ready && bus.in_valid;

  // One extra bit keeps base+pairs exact, so the depth check never wraps
  assign w_pairs = {1'b0, word_count[INS_ADDRESS:1]} + {{INS_ADDRESS{1'b0}}, word_count[0]};
  assign w_end   = {1'b0, base_addr} + w_pairs;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    lo_d         = lo_q;
    load_addr_d  = load_addr_q;
    load_data1_d = load_data1_q;
    load_data2_d = load_data2_q;
    overflow_d   = overflow_q;

    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            if (w_end > SLOT_LIMIT) begin
              overflow_d = 1'b1;
              state_d    = IDLE;
            end else if (word_count == '0) begin
              overflow_d = 1'b0;
              state_d    = DONE;
            end else begin
              overflow_d  = 1'b0;
              addr_d      = base_addr;
              remaining_d = word_count;
              state_d     = FILL_LO;
            end
          end
        end
        FILL_LO: begin
          if (w_handshake) begin
            remaining_d = remaining_q - ONE_WORD;
            if (remaining_q > ONE_WORD) begin
              lo_d    = bus.in_data;
              state_d = FILL_HI;
            end else begin
              // Odd tail: the pair is padded with a zero upper word
              load_addr_d  = addr_q;
              load_data1_d = bus.in_data;
              load_data2_d = '0;
              state_d      = WRITE;
            end
          end
        end
        FILL_HI: begin
          if (w_handshake) begin
            remaining_d  = remaining_q - ONE_WORD;
            load_addr_d  = addr_q;
            load_data1_d = lo_q;
            load_data2_d = bus.in_data;
            state_d      = WRITE;
          end
        end
        WRITE: begin
          addr_d  = addr_q + ONE_SLOT;
          state_d = (remaining_q != '0) ? FILL_LO : DONE;
        end
        default: state_d = IDLE;
      endcase
    end

    load_en_d = (state_d == WRITE);
    busy_d    = (state_d == FILL_LO) || (state_d == FILL_HI) || (state_d == WRITE);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      remaining_q  <= '0;
      lo_q         <= '0;
      load_en_q    <= 1'b0;
      load_addr_q  <= '0;
      load_data1_q <= '0;
      load_data2_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      lo_q         <= lo_d;
      load_en_q    <= load_en_d;
      load_addr_q  <= load_addr_d;
      load_data1_q <= load_data1_d;
      load_data2_q <= load_data2_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.load_en    = load_en_q;
  assign bus.load_addr  = load_addr_q;
  assign bus.load_data1 = load_data1_q;
  assign bus.load_data2 = load_data2_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign overflow       = overflow_q;
  assign core_run       = done_q;

endmodule

`default_nettype wire
